banner_row_reader: RTL
======================

Name: banner_row_reader

Overview:
- Reads a banner bitmap ROM row by row and serialises a horizontally scrolling window of it onto a 1-bit pixel stream for the LED-matrix driver.
- Sits between a banner word ROM and the matrix shift logic. The ROM has 5-bit address in, 70-bit row out, and one-cycle registered-address latency.
- Drives the ROM address, captures each row, and rotates it by the current scroll offset. It then shifts WIN pixels out per row under valid/ready.

Parameters:
- ROWS, 15, number of bitmap rows fetched per frame (addresses 0..ROWS-1).
- COLS, 70, ROM row width in pixels; column 0 is ROM bit COLS-1 (MSB).
- WIN, 32, visible window width in pixels per row (WIN <= COLS).
- ADDR_W, 5, ROM address width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  pulse; begins one frame when idle.
- step  in  1  pulse; request scroll offset +1 at next frame end.
- rom_address  out  ADDR_W  row address to banner ROM.
- rom_data  in  COLS  ROM row data; valid the cycle after rom_address is presented.
- pix_data  out  1  current pixel.
- pix_valid  out  1  pix_data valid.
- pix_ready  in  1  consumer accepts pixel this cycle.
- row_idx  out  ADDR_W  row currently being shifted.
- row_last  out  1  high with pix_valid on the final pixel of a row.
- frame_done  out  1  one-cycle pulse after the last pixel of the last row.
- busy  out  1  high from start acceptance until frame_done.

Behaviour:
- Reset values: all outputs 0. State IDLE, offset 0, step_pending 0, row buffer 0.
- States:
  - IDLE: busy=0. start=1 -> FETCH with row=0.
  - FETCH: rom_address=row; go to LATCH next cycle.
  - LATCH: rom_data is valid now.
    - Load buf = rom_data rotated left by offset, so buf[COLS-1-k] = pixel at column (offset+k) mod COLS.
    - Set pixel count=0, then go to SHIFT.
  - SHIFT: pix_valid=1, pix_data=buf[COLS-1-count], row_idx=row, row_last=(count==WIN-1).
    - Each cycle with pix_valid&pix_ready, count increments.
    - On handshake of count==WIN-1: if row==ROWS-1 -> DONE, else row+1 and FETCH.
  - DONE: frame_done=1 for one cycle.
    - If step_pending, offset=(offset==COLS-1)?0:offset+1 and step_pending clears.
    - Go to IDLE.
- Minimum frame latency, start accepted to first pix_valid: 2 cycles (FETCH, LATCH).
- Between rows: 2 cycles with pix_valid=0 (FETCH, LATCH).
- Handshake:
  - pix_data, row_last and row_idx hold stable while pix_valid=1 and pix_ready=0.
  - pix_valid never drops without a handshake except on rst.
- rom_address holds its last value outside FETCH. The ROM may be read at any time; only the LATCH cycle matters.
- start while busy: ignored, no queuing.
- step: sets step_pending in any state. Multiple pulses within one frame give a single +1. A step arriving in the DONE cycle applies at the following frame end.
- Offset wrap: at COLS-1 the next value is 0.
  - Window columns wrap modulo COLS, e.g. offset 60, WIN 32 -> columns 60..69 then 0..21.
- rst mid-frame: immediate return to IDLE; offset and step_pending clear; no frame_done.
- Width rules:
  - offset is ceil(log2(COLS)) bits; count is ceil(log2(WIN)) bits.
  - Rotation is combinational on rom_data in LATCH and registered into buf.

Decomposition:
- Shared package banner_pkg: COLS, ROWS, WIN, ADDR_W constants, state enum (IDLE, FETCH, LATCH, SHIFT, DONE), and the offset-width constant.
- One natural sub-module, banner_rotate: a combinational parameterised rotate-left of COLS bits by offset, reusable by a future vertical scroller.

Test Plan:
- Bench ROM model with one-cycle registered-address latency; row 0 = 1111110001111111110001111110000001111110000000000001111111110001111110.
- Reset, start, pix_ready=1, offset 0 -> first pix_valid 2 cycles after start; row 0 first 12 pixels 111111000111; row_last on pixel 31; frame_done after ROWS*(WIN+2)+1 cycles.
- Scroll: 3 step pulses in frame 1, then frame 2 -> offset 1 only; row 0 first pixels 11111000111.
- Wrap: drive 65 frames each with one step -> offset 65; row 0 pixels = columns 65..69 then 0..26, starting 11110111111.
- Backpressure: pix_ready toggles 1,0,0,1 and is held 0 for 5 cycles mid-row -> pix_data/row_idx stable while stalled; no pixels lost or duplicated; 32 pixels per row.
- Reset mid-row 3 plus start while busy -> rst gives all outputs 0, offset 0, no frame_done; start during SHIFT has no effect on row sequence.

Source files
------------

// File: rtl/banner_pkg.sv
// banner_pkg: shared sizes and FSM state type for the banner row reader and its rotator
package banner_pkg;
  localparam int ROWS = 15;
  localparam int COLS = 70;
  localparam int WIN = 32;
  localparam int ADDR_W = 5;
  localparam int OFF_W = $clog2(COLS);
  localparam int CNT_W = $clog2(WIN);
  typedef enum logic [2:0] {IDLE, FETCH, LATCH, SHIFT, DONE} state_t;
endpackage

// File: rtl/banner_rotate.sv
// banner_rotate: combinational rotate-left of din by amt (amt < W); ports din/amt in, dout out
module banner_rotate #(
  parameter int W = banner_pkg::COLS,
  parameter int SW = banner_pkg::OFF_W
) (
  input  logic [W-1:0]  din,
  input  logic [SW-1:0] amt,
  output logic [W-1:0]  dout
);
  logic [2*W-1:0] dbl;
  always_comb begin
    dbl = {din, din} << amt;
    dout = dbl[2*W-1:W];
  end
endmodule

// File: rtl/banner_row_reader.sv
// banner_row_reader: fetches banner ROM rows, rotates by scroll offset, streams WIN pixels/row; ports: start/step control, rom_address/rom_data ROM side, pix_* valid/ready stream, row_idx/row_last/frame_done/busy status
module banner_row_reader
  import banner_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              step,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [COLS-1:0]   rom_data,
  output logic              pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [ADDR_W-1:0] row_idx,
  output logic              row_last,
  output logic              frame_done,
  output logic              busy
);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] row_q, row_d, addr_q, addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OFF_W-1:0] off_q, off_d;
  logic step_q, step_d;
  logic [COLS-1:0] row_buf_q, row_buf_d, rot;
  logic shift, cnt_end, row_end;

  banner_rotate #(.W(COLS), .SW(OFF_W)) u_rot (.din(rom_data), .amt(off_q), .dout(rot));

  // The row buffer shifts left on each accepted pixel, so the current pixel is always its MSB.
  always_comb begin
    shift = state_q == SHIFT;
    cnt_end = cnt_q == CNT_W'(WIN - 1);
    row_end = row_q == ADDR_W'(ROWS - 1);
    state_d = state_q;
    row_d = row_q;
    cnt_d = cnt_q;
    row_buf_d = row_buf_q;
    off_d = off_q;
    addr_d = state_q == FETCH ? row_q : addr_q;
    // A step landing in the DONE cycle survives to the next frame end.
    step_d = state_q == DONE ? step : step_q | step;
    case (state_q)
      IDLE: if (start) begin
        state_d = FETCH;
        row_d = '0;
      end
      FETCH: state_d = LATCH;
      LATCH: begin
        row_buf_d = rot;
        cnt_d = '0;
        state_d = SHIFT;
      end
      SHIFT: if (pix_ready) begin
        row_buf_d = row_buf_q << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_end) begin
          state_d = row_end ? DONE : FETCH;
          row_d = row_end ? row_q : row_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        off_d = !step_q ? off_q : off_q == OFF_W'(COLS - 1) ? '0 : off_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    rom_address = state_q == FETCH ? row_q : addr_q;
    pix_valid = shift;
    pix_data = shift & row_buf_q[COLS-1];
    row_idx = shift ? row_q : '0;
    row_last = shift & cnt_end;
    frame_done = state_q == DONE;
    busy = state_q != IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      row_q <= '0;
      addr_q <= '0;
      cnt_q <= '0;
      off_q <= '0;
      step_q <= 1'b0;
      row_buf_q <= '0;
    end else begin
      state_q <= state_d;
      row_q <= row_d;
      addr_q <= addr_d;
      cnt_q <= cnt_d;
      off_q <= off_d;
      step_q <= step_d;
      row_buf_q <= row_buf_d;
    end
  end
endmodule
